fetch_ctrl: RTL and testbench



---
 rtl/fetch_ctrl_if.sv | 47 ++++
 rtl/fetch_ctrl.sv | 127 ++++++++++++
 tb/tb_fetch_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_if
// Description : Fetch-stage bus bundle. Carries the instruction-memory read
//               port and the decode-side valid/ready instruction handshake.
//               The master side is the fetch controller. The slave side is
//               the memory/decode environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if #(
    parameter int XLEN = 32
);
    // instruction memory read port
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;

    // decode handshake
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_pc_nxt;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        output if_valid,
        input  if_ready,
        output if_instr,
        output if_pc,
        output if_pc_nxt
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        input  if_valid,
        output if_ready,
        input  if_instr,
        input  if_pc,
        input  if_pc_nxt
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch sequencer. Owns the word-addressed PC,
//               issues single-cycle-latency reads to the instruction memory,
//               buffers returned words in a 2-entry FIFO and hands them to
//               decode over valid/ready. Execute redirects flush everything.
//               Halt only blocks new issues.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            redirect_valid,
    input  wire logic [XLEN-1:0] redirect_pc,
    input  wire logic            halt,
    fetch_ctrl_if.master         bus,
    output logic                 busy
);

    localparam logic [1:0] c_fifo_full = 2'd2;

    // PC and the single outstanding memory read
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_tag;
    logic            r_inflight;

    // 2-entry circular FIFO of {instruction, pc}
    logic [XLEN-1:0] r_fifo_instr [2];
    logic [XLEN-1:0] r_fifo_pc    [2];
    logic            r_wptr;
    logic            r_rptr;
    logic [1:0]      r_count;

    logic            w_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [2:0]      w_occ;
    logic            w_nonempty;
    logic [XLEN-1:0] w_head_pc;

    // Handshake, issue and push decisions for this cycle
    always_comb begin
        w_nonempty = (r_count != 2'd0);
        // A redirect kills the output in the same cycle so stale instructions
        // are never consumed alongside the PC change.
        w_valid    = w_nonempty & ~redirect_valid;
        w_pop      = w_valid & bus.if_ready;
        // Slots that will be occupied once this cycle's pop and the pending
        // return settle. A new read may go out only if its data has a place
        // to land next cycle. This is what keeps pushes off a full FIFO.
        w_occ      = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_issue    = ~rst & ~halt & ~redirect_valid & (w_occ < 3'd2);
        // Returning data belongs to the old path when a redirect arrives.
        w_push     = r_inflight & ~redirect_valid;
        w_head_pc  = w_nonempty ? r_fifo_pc[r_rptr] : '0;
    end

    assign bus.imem_req  = w_issue;
    assign bus.imem_addr = r_pc;
    assign bus.if_valid  = w_valid;
    // Head fields read as zero while empty so an idle stage presents a clean bus.
    assign bus.if_instr  = w_nonempty ? r_fifo_instr[r_rptr] : '0;
    assign bus.if_pc     = w_head_pc;
    assign bus.if_pc_nxt = w_nonempty ? (w_head_pc + {{(XLEN-1){1'b0}}, 1'b1}) : '0;
    assign busy          = r_inflight | w_nonempty;

    // PC, in-flight flag and tag update: reset, then redirect, then issue
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_tag      <= '0;
            r_inflight <= 1'b0;
        end else if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_pc       <= r_pc + {{(XLEN-1){1'b0}}, 1'b1};
            r_tag      <= r_pc;
            r_inflight <= 1'b1;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    // FIFO pointers and occupancy, flushed on reset or redirect
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage write; contents are only observed while the count is non-zero
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_fifo_instr[r_wptr] <= bus.imem_rdata;
            r_fifo_pc[r_wptr]    <= r_tag;
        end
    end

    // The issue rule must never let a return arrive with both slots occupied,
    // and a pop can never occur on an empty FIFO.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        w_push |-> (r_count != c_fifo_full));
    a_no_pop_when_empty: assert property (@(posedge clk) disable iff (rst)
        w_pop |-> (r_count != 2'd0));

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Directed self-checking bench for fetch_ctrl. A one-cycle
//               instruction memory returns (addr ^ c_key). Each cycle the
//               inputs are set just after the rising edge and the outputs are
//               compared against hand-derived values before the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam int          XLEN  = 32;
    localparam logic [31:0] c_key = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        busy;

    int total = 0;
    int bad   = 0;

    fetch_ctrl_if #(.XLEN(XLEN)) bus ();

    fetch_ctrl #(
        .XLEN     (XLEN),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .bus            (bus.master),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data appears the cycle after the request
    always @(posedge clk) begin
        if (bus.imem_req) begin
            bus.imem_rdata <= bus.imem_addr ^ c_key;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle, then apply this cycle's inputs and let them settle
    task automatic next_cycle(input logic rv, input logic [31:0] rpc, input logic h,
                              input logic rdy, input logic r);
        @(posedge clk);
        #1;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt           = h;
        bus.if_ready   = rdy;
        rst            = r;
        #1;
    endtask

    task automatic expect_fetch(input string tag, input logic req, input logic [31:0] addr);
        check({tag, "_req"}, {31'b0, bus.imem_req}, {31'b0, req});
        if (req) begin
            check({tag, "_addr"}, bus.imem_addr, addr);
        end
    endtask

    task automatic expect_out(input string tag, input logic vld, input logic [31:0] pc);
        logic [31:0] nxt;
        nxt = pc + 32'd1;
        check({tag, "_valid"}, {31'b0, bus.if_valid}, {31'b0, vld});
        if (vld) begin
            check({tag, "_pc"},    bus.if_pc,     pc);
            check({tag, "_pcnxt"}, bus.if_pc_nxt, nxt);
            check({tag, "_instr"}, bus.if_instr,  pc ^ c_key);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        bus.if_ready   = 1'b1;

        // reset state
        next_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        next_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("rst_req",   {31'b0, bus.imem_req}, 32'd0);
        check("rst_valid", {31'b0, bus.if_valid}, 32'd0);
        check("rst_busy",  {31'b0, busy},         32'd0);
        check("rst_instr", bus.if_instr,          32'd0);
        check("rst_pc",    bus.if_pc,             32'd0);
        check("rst_pcnxt", bus.if_pc_nxt,         32'd0);

        // streaming start after reset release
        next_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);            // c0
        expect_fetch("c0", 1'b1, 32'd0);
        expect_out("c0", 1'b0, 32'd0);
        next_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);            // c1
        expect_fetch("c1", 1'b1, 32'd1);
        expect_out("c1", 1'b0, 32'd0);
        check("c1_busy", {31'b0, busy}, 32'd1);
        next_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);            // c2
        expect_fetch("c2", 1'b1, 32'd2);
        expect_out("c2", 1'b1, 32'd0);

        // decode stall for five cycles: FIFO fills, requests stop
        next_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);            // c3
        expect_fetch("c3", 1'b0, 32'd0);
        expect_out("c3", 1'b1, 32'd1);
        for (int i = 4; i <= 7; i++) begin
            next_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            expect_fetch($sformatf("c%0d", i), 1'b0, 32'd0);
            expect_out($sformatf("c%0d", i), 1'b1, 32'd1);
        end

        // release: in order, no drops, back to one per cycle
        for (int i = 0; i < 4; i++) begin
            next_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);        // c8..c11
            expect_fetch($sformatf("rel%0d", i), 1'b1, 32'd3 + i);
            expect_out($sformatf("rel%0d", i), 1'b1, 32'd1 + i);
        end

        // redirect to 0x40 while an entry is buffered and a read is in flight
        next_cycle(1'b1, 32'h40, 1'b0, 1'b1, 1'b0);           // c12
        expect_fetch("rd_c0", 1'b0, 32'd0);
        expect_out("rd_c0", 1'b0, 32'd0);
        check("rd_c0_busy", {31'b0, busy}, 32'd1);
        next_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);            // c13
        expect_fetch("rd_c1", 1'b1, 32'h40);
        expect_out("rd_c1", 1'b0, 32'd0);
        check("rd_c1_busy", {31'b0, busy}, 32'd0);
        next_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);            // c14
        expect_fetch("rd_c2", 1'b1, 32'h41);
        expect_out("rd_c2", 1'b0, 32'd0);
        next_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);            // c15
        expect_fetch("rd_c3", 1'b1, 32'h42);
        expect_out("rd_c3", 1'b1, 32'h40);
        next_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);            // c16
        expect_out("rd_c4", 1'b1, 32'h41);

        // redirect to the top of the address space: PC wraps to zero
        next_cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);    // c17
        expect_fetch("wr_c0", 1'b0, 32'd0);
        expect_out("wr_c0", 1'b0, 32'd0);
        next_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);            // c18
        expect_fetch("wr_c1", 1'b1, 32'hFFFF_FFFF);
        next_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);            // c19
        expect_fetch("wr_c2", 1'b1, 32'd0);
        expect_out("wr_c2", 1'b0, 32'd0);
        next_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);            // c20
        expect_fetch("wr_c3", 1'b1, 32'd1);
        expect_out("wr_c3", 1'b1, 32'hFFFF_FFFF);
        check("wr_c3_pcnxt0", bus.if_pc_nxt, 32'd0);
        next_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);            // c21
        expect_fetch("wr_c4", 1'b1, 32'd2);
        expect_out("wr_c4", 1'b1, 32'd0);

        // halt mid-stream: issue stops at once, pipeline drains
        next_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);            // c22
        expect_fetch("ht_c0", 1'b0, 32'd0);
        expect_out("ht_c0", 1'b1, 32'd1);
        next_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);            // c23
        expect_fetch("ht_c1", 1'b0, 32'd0);
        expect_out("ht_c1", 1'b1, 32'd2);
        check("ht_c1_busy", {31'b0, busy}, 32'd1);
        next_cycle(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);            // c24
        expect_fetch("ht_c2", 1'b0, 32'd0);
        expect_out("ht_c2", 1'b0, 32'd0);
        check("ht_c2_busy", {31'b0, busy}, 32'd0);
        next_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);            // c25
        expect_fetch("ht_c3", 1'b1, 32'd3);
        next_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);            // c26
        expect_fetch("ht_c4", 1'b1, 32'd4);
        expect_out("ht_c4", 1'b0, 32'd0);

        // reset pulse with an entry buffered and a read in flight
        next_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);            // c27
        expect_fetch("rp_c0", 1'b0, 32'd0);
        next_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);            // c28
        expect_fetch("rp_c1", 1'b1, 32'd0);
        expect_out("rp_c1", 1'b0, 32'd0);
        check("rp_c1_busy", {31'b0, busy}, 32'd0);
        next_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);            // c29
        expect_fetch("rp_c2", 1'b1, 32'd1);
        expect_out("rp_c2", 1'b0, 32'd0);
        next_cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);            // c30
        expect_out("rp_c3", 1'b1, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
